// File: rtl/i2c_burst_write_pkg.sv
// Shared definitions for the I2C burst-write engine: FSM encodings, bit-cell
// constants and bus polarity constants.
package i2c_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ARM_WAIT = 4'd1;
    localparam logic [3:0] S_START_A  = 4'd2;
    localparam logic [3:0] S_START_B  = 4'd3;
    localparam logic [3:0] S_BIT_A    = 4'd4;
    localparam logic [3:0] S_BIT_B    = 4'd5;
    localparam logic [3:0] S_BIT_C    = 4'd6;
    localparam logic [3:0] S_STOP_A   = 4'd7;
    localparam logic [3:0] S_STOP_B   = 4'd8;
    localparam logic [3:0] S_STOP_C   = 4'd9;

    typedef enum logic [3:0] {
        IDLE     = S_IDLE,
        ARM_WAIT = S_ARM_WAIT,
        START_A  = S_START_A,
        START_B  = S_START_B,
        BIT_A    = S_BIT_A,
        BIT_B    = S_BIT_B,
        BIT_C    = S_BIT_C,
        STOP_A   = S_STOP_A,
        STOP_B   = S_STOP_B,
        STOP_C   = S_STOP_C
    } state_t;

    localparam int unsigned CELLS_PER_BYTE = 9;
    localparam logic [3:0]  ACK_CELL       = 4'd8;
    localparam logic        ACK            = 1'b0;
    localparam logic        W_BIT          = 1'b0;

endpackage

// File: rtl/i2c_burst_write_if.sv
// Control/bus bundle of the I2C burst-write engine. SCLI exists only when
// I2C_CLK_STRETCH_EN is defined.
interface i2c_burst_write_if #(
    parameter int PTR_BYTES = 1,
    parameter int MAX_BYTES = 4,
    parameter int CW        = $clog2(MAX_BYTES + 1)
);
    logic                   GO;
    logic [6:0]             SLAVE_ADDRESS;
    logic [8*PTR_BYTES-1:0] POINTER;
    logic [8*MAX_BYTES-1:0] DATA;
    logic [CW-1:0]          NUM_BYTES;
    logic                   SDAI;
`ifdef I2C_CLK_STRETCH_EN
    logic                   SCLI;
`endif
    logic                   SDAO;
    logic                   SCLO;
    logic                   END_OK;
    logic                   ACK_OK;
    logic                   NACK_ERR;
    logic [CW-1:0]          BYTE_IDX;

    modport master (
        input  GO, SLAVE_ADDRESS, POINTER, DATA, NUM_BYTES, SDAI,
`ifdef I2C_CLK_STRETCH_EN
        input  SCLI,
`endif
        output SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_IDX
    );

    modport slave (
        output GO, SLAVE_ADDRESS, POINTER, DATA, NUM_BYTES, SDAI,
`ifdef I2C_CLK_STRETCH_EN
        output SCLI,
`endif
        input  SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_IDX
    );

endinterface

// File: rtl/i2c_burst_write_byte_shifter.sv
// Byte serialiser: shifts a loaded byte MSB-first over 8 cells, then releases
// SDA for the 9th (ACK) cell and reports the slave's answer.
module i2c_byte_shifter
    import i2c_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_next,
    input  logic       i_sdai,
    output logic       o_sda,
    output logic       o_ack_bit,
    output logic       o_byte_done
);

    logic [8:0] r_sr;
    logic [3:0] r_cell;

    // A 1 is appended so the ACK cell naturally releases SDA.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr   <= '1;
            r_cell <= '0;
        end else if (i_load) begin
            r_sr   <= {i_byte, 1'b1};
            r_cell <= '0;
        end else if (i_next) begin
            r_sr   <= {r_sr[7:0], 1'b1};
            r_cell <= r_cell + 4'd1;
        end
    end

    assign o_sda       = r_sr[8];
    assign o_byte_done = (r_cell == ACK_CELL);
    assign o_ack_bit   = (i_sdai == ACK);

endmodule

// File: rtl/i2c_burst_write.sv
// I2C master burst write: START, address+W, pointer, payload, STOP, with ACK
// checking. Optional clock stretching via I2C_CLK_STRETCH_EN.
module i2c_burst_write
    import i2c_pkg::*;
#(
    parameter int PTR_BYTES = 1,
    parameter int MAX_BYTES = 4,
    parameter int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                  PT_CK,
    input  logic                  RESET_N,
    i2c_burst_write_if.master     bus
);

    localparam int IW = $clog2(PTR_BYTES + MAX_BYTES + 2);

    state_t                 r_state;
    logic                   r_armed;
    logic                   r_end_ok;
    logic                   r_ack_ok;
    logic                   r_nack;
    logic [IW-1:0]          r_idx;
    logic [6:0]             r_addr;
    logic [8*PTR_BYTES-1:0] r_ptr;
    logic [8*MAX_BYTES-1:0] r_data;
    logic [CW-1:0]          r_num;

    logic [IW-1:0] w_last_idx;
    logic [IW-1:0] w_sel;
    logic [7:0]    w_byte;
    logic          w_load;
    logic          w_next;
    logic          w_bit;
    logic          w_acked;
    logic          w_byte_done;
    logic          w_stretch;
    logic          w_sdao;
    logic          w_sclo;

`ifdef I2C_CLK_STRETCH_EN
    assign w_stretch = ~bus.SCLI;
`else
    assign w_stretch = 1'b0;
`endif

    assign w_last_idx = IW'(PTR_BYTES) + IW'(r_num);
    assign w_sel      = (r_state == START_A) ? '0 : r_idx + IW'(1);

    // Byte order on the wire: address+W, pointer MSB..LSB, payload 0..N-1.
    always_comb begin
        w_byte = {r_addr, W_BIT};
        for (int unsigned k = 0; k < PTR_BYTES; k++)
            if (w_sel == IW'(k + 1)) w_byte = r_ptr[8*(PTR_BYTES-1-k) +: 8];
        for (int unsigned k = 0; k < MAX_BYTES; k++)
            if (w_sel == IW'(k + 1 + PTR_BYTES)) w_byte = r_data[8*k +: 8];
    end

    always_comb begin
        w_load = 1'b0;
        w_next = 1'b0;
        case (r_state)
            START_A: w_load = 1'b1;
            BIT_C: begin
                if (!w_byte_done)                         w_next = 1'b1;
                else if (w_acked && r_idx != w_last_idx)  w_load = 1'b1;
            end
            default: ;
        endcase
    end

    i2c_byte_shifter u_shifter (
        .i_clk       (PT_CK),
        .i_rst_n     (RESET_N),
        .i_load      (w_load),
        .i_byte      (w_byte),
        .i_next      (w_next),
        .i_sdai      (bus.SDAI),
        .o_sda       (w_bit),
        .o_ack_bit   (w_acked),
        .o_byte_done (w_byte_done)
    );

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_armed  <= 1'b0;
            r_end_ok <= 1'b1;
            r_ack_ok <= 1'b0;
            r_nack   <= 1'b0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_ptr    <= '0;
            r_data   <= '0;
            r_num    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.GO && r_armed) begin
                        r_addr   <= bus.SLAVE_ADDRESS;
                        r_ptr    <= bus.POINTER;
                        r_data   <= bus.DATA;
                        r_num    <= (bus.NUM_BYTES > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : bus.NUM_BYTES;
                        r_idx    <= '0;
                        r_armed  <= 1'b0;
                        r_end_ok <= 1'b0;
                        r_ack_ok <= 1'b0;
                        r_nack   <= 1'b0;
                        r_state  <= START_A;
                    end else if (!bus.GO) begin
                        r_armed <= 1'b1;
                    end
                end
                ARM_WAIT: begin
                    if (!bus.GO) begin
                        r_armed <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                START_A: r_state <= START_B;
                START_B: r_state <= BIT_A;
                BIT_A:   r_state <= BIT_B;
                BIT_B:   if (!w_stretch) r_state <= BIT_C;
                BIT_C: begin
                    if (!w_byte_done) begin
                        r_state <= BIT_A;
                    end else if (w_acked) begin
                        r_idx   <= r_idx + IW'(1);
                        r_state <= (r_idx == w_last_idx) ? STOP_A : BIT_A;
                    end else begin
                        r_nack  <= 1'b1;
                        r_state <= STOP_A;
                    end
                end
                STOP_A:  r_state <= STOP_B;
                STOP_B:  if (!w_stretch) r_state <= STOP_C;
                STOP_C: begin
                    r_end_ok <= 1'b1;
                    r_ack_ok <= ~r_nack;
                    r_state  <= ARM_WAIT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_sdao = 1'b1;
        w_sclo = 1'b1;
        case (r_state)
            START_B: w_sdao = 1'b0;
            BIT_A: begin
                w_sclo = 1'b0;
                w_sdao = w_bit;
            end
            BIT_B, BIT_C: w_sdao = w_bit;
            STOP_A: begin
                w_sdao = 1'b0;
                w_sclo = 1'b0;
            end
            STOP_B: w_sdao = 1'b0;
            default: ;
        endcase
    end

    assign bus.SDAO     = w_sdao;
    assign bus.SCLO     = w_sclo;
    assign bus.END_OK   = r_end_ok;
    assign bus.ACK_OK   = r_ack_ok;
    assign bus.NACK_ERR = r_nack;
    assign bus.BYTE_IDX = r_idx[CW-1:0];

endmodule
